// File: rtl/sigcapture_if.sv
// Sample stream between the mic/write side and the playback consumer.
// The source side drives en and mic_signal and receives the replayed samples.
interface sigcapture_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en;
    logic [DATA_WIDTH-1:0] mic_signal;
    logic [DATA_WIDTH-1:0] playback_signal;
    logic                  valid;

    modport master (
        output en,
        output mic_signal,
        input  playback_signal,
        input  valid
    );

    modport slave (
        input  en,
        input  mic_signal,
        output playback_signal,
        output valid
    );
endinterface

// File: rtl/sigcapture.sv
// Triggered record-and-playback buffer: waits for a rising level crossing,
// records a fixed window into a 2-port RAM, then replays it in a loop.
module sigcapture #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [DATA_WIDTH-1:0]    trigger_level,
    input  logic [ADDRESS_WIDTH-1:0] length,
    sigcapture_if.slave              stream,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURE  = 2'd2,
        PLAYBACK = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr, wr_addr_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr, rd_addr_d;
    logic [ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [ADDRESS_WIDTH-1:0] wr_sel;
    logic [ADDRESS_WIDTH-1:0] last;
    logic [DATA_WIDTH-1:0]    prev_sample;
    logic                     wr_en;
    logic                     rd_en;
    logic                     done_d;
    logic                     trig;

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    // len_q == 0 wraps to all ones, which is exactly the full-depth last address
    assign last = len_q - ONE;
    assign trig = stream.en
               && (stream.mic_signal >= trigger_level)
               && (prev_sample < trigger_level);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr;
        rd_addr_d = rd_addr;
        len_d     = len_q;
        wr_sel    = wr_addr;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    len_d   = length;
                end
            end
            ARMED: begin
                if (trig) begin
                    wr_en  = 1'b1;
                    wr_sel = '0;
                    if (last == '0) begin
                        state_d   = PLAYBACK;
                        done_d    = 1'b1;
                        rd_addr_d = '0;
                    end else begin
                        state_d   = CAPTURE;
                        wr_addr_d = ONE;
                    end
                end
            end
            CAPTURE: begin
                if (stream.en) begin
                    wr_en = 1'b1;
                    if (wr_addr == last) begin
                        state_d   = PLAYBACK;
                        done_d    = 1'b1;
                        rd_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr + ONE;
                    end
                end
            end
            PLAYBACK: begin
                if (stream.en) begin
                    rd_en     = 1'b1;
                    rd_addr_d = (rd_addr == last) ? '0 : rd_addr + ONE;
                end
                if (arm) begin
                    state_d = ARMED;
                    len_d   = length;
                end
            end
            default: state_d = IDLE;
        endcase
        // stop overrides arm and trigger; a read issued this cycle still lands
        if (stop) begin
            state_d   = IDLE;
            wr_en     = 1'b0;
            done_d    = 1'b0;
            wr_addr_d = wr_addr;
            len_d     = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            len_q       <= '0;
            prev_sample <= '0;
            done        <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_addr <= wr_addr_d;
            rd_addr <= rd_addr_d;
            len_q   <= len_d;
            done    <= done_d;
            if (stream.en) begin
                prev_sample <= stream.mic_signal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel] <= stream.mic_signal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stream.playback_signal <= '0;
            stream.valid           <= 1'b0;
        end else begin
            stream.valid <= rd_en;
            if (rd_en) begin
                stream.playback_signal <= mem[rd_addr];
            end
        end
    end

    assign busy  = (state_q == ARMED) || (state_q == CAPTURE);
    assign state = state_q;
endmodule

// File: tb/tb_sigcapture.sv
// Bench for sigcapture: vector table for the basic capture/replay path,
// plus a playback scoreboard for gating, precedence, reset and depth cases.
module tb_sigcapture;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          stop;
    logic [DW-1:0] trigger_level;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    sigcapture_if #(.DATA_WIDTH(DW)) bus ();

    sigcapture #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .stop          (stop),
        .trigger_level (trigger_level),
        .length        (length),
        .stream        (bus),
        .busy          (busy),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] win [512];
    int            win_len = 1;
    int            pb_idx  = 0;
    bit            pb      = 1'b0;
    bit            sb_on   = 1'b0;

    typedef struct {
        logic          a;
        logic          e;
        logic [DW-1:0] mic;
        logic [1:0]    st;
        logic          bsy;
        logic          dn;
        logic          vld;
        logic [DW-1:0] play;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // one clock; pushes the expected replay sample whenever a read is issued
    task automatic cyc(input logic e, input logic [DW-1:0] m,
                       input logic a, input logic s);
        bus.en         = e;
        bus.mic_signal = m;
        arm            = a;
        stop           = s;
        if (pb && e) begin
            exp_q.push_back(win[pb_idx]);
            pb_idx = (pb_idx + 1) % win_len;
        end
        if (a || s) pb = 1'b0;
        @(posedge clk);
        #1;
        arm  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic start_pb(input int n);
        win_len = n;
        pb_idx  = 0;
        pb      = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_on && bus.valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(bus.playback_signal), 32'hFFFF);
            end else begin
                chk("sb_sample", 32'(bus.playback_signal), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        arm            = 1'b0;
        stop           = 1'b0;
        bus.en         = 1'b0;
        bus.mic_signal = '0;
        trigger_level  = 8'h80;
        length         = 9'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_play", 32'(bus.playback_signal), 0);
        rst = 1'b0;

        // basic capture of 0x90..0xC0, then looping replay
        tv[0]  = '{1'b1, 1'b1, 8'h10, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[1]  = '{1'b0, 1'b1, 8'h20, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[2]  = '{1'b0, 1'b1, 8'h90, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[3]  = '{1'b0, 1'b1, 8'hA0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[4]  = '{1'b0, 1'b1, 8'hB0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[5]  = '{1'b0, 1'b1, 8'hC0, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[6]  = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'h90};
        tv[7]  = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'hA0};
        tv[8]  = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'hB0};
        tv[9]  = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'hC0};
        tv[10] = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'h90};
        tv[11] = '{1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 8'h90};
        tv[12] = '{1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 8'hA0};
        for (int i = 0; i < 13; i++) begin
            cyc(tv[i].e, tv[i].mic, tv[i].a, 1'b0);
            chk($sformatf("tv%0d_state", i), 32'(state), 32'(tv[i].st));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("tv%0d_done", i), 32'(done), 32'(tv[i].dn));
            chk($sformatf("tv%0d_valid", i), 32'(bus.valid), 32'(tv[i].vld));
            chk($sformatf("tv%0d_play", i), 32'(bus.playback_signal), 32'(tv[i].play));
        end

        // arm+stop together in playback: stop wins, in-flight read lands
        cyc(1'b1, 8'h00, 1'b1, 1'b1);
        chk("armstop_state", 32'(state), 0);
        chk("armstop_valid", 32'(bus.valid), 1);
        chk("armstop_play", 32'(bus.playback_signal), 32'h B0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("idle_valid", 32'(bus.valid), 0);
        chk("idle_hold", 32'(bus.playback_signal), 32'hB0);

        sb_on = 1'b1;

        // high sample already present at arm time must not trigger
        length = 9'd3;
        cyc(1'b1, 8'h90, 1'b0, 1'b0);
        cyc(1'b1, 8'h95, 1'b1, 1'b0);
        chk("nf_armed", 32'(state), 1);
        cyc(1'b1, 8'h95, 1'b0, 1'b0);
        chk("nf_hold", 32'(state), 1);
        cyc(1'b1, 8'h40, 1'b0, 1'b0);
        chk("nf_low", 32'(state), 1);
        cyc(1'b1, 8'h81, 1'b0, 1'b0);
        chk("nf_trig", 32'(state), 2);

        // en gating during capture, length 3
        cyc(1'b0, 8'h11, 1'b0, 1'b0);
        chk("gate_cap0", 32'(state), 2);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 8'h33, 1'b0, 1'b0);
        chk("gate_cap1", 32'(state), 2);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        chk("gate_done", 32'(done), 1);
        chk("gate_pb", 32'(state), 3);
        win[0] = 8'h81;
        win[1] = 8'h22;
        win[2] = 8'h44;
        start_pb(3);
        for (int i = 0; i < 8; i++) begin
            logic e;
            e = (i < 4) ? logic'(i % 2 == 0) : 1'b1;
            cyc(e, 8'h00, 1'b0, 1'b0);
            chk($sformatf("gate_valid%0d", i), 32'(bus.valid), 32'(e));
        end

        // arm in playback: one in-flight read, then valid drops
        length = 9'd3;
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        chk("rearm_state", 32'(state), 1);
        chk("rearm_valid", 32'(bus.valid), 1);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("rearm_drop", 32'(bus.valid), 0);

        // arm during capture is ignored, length stays 3
        cyc(1'b1, 8'h90, 1'b0, 1'b0);
        length = 9'd5;
        cyc(1'b1, 8'h91, 1'b1, 1'b0);
        chk("capign_state", 32'(state), 2);
        cyc(1'b1, 8'h92, 1'b0, 1'b0);
        chk("capign_done", 32'(state), 3);
        win[0] = 8'h90;
        win[1] = 8'h91;
        win[2] = 8'h92;
        start_pb(3);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);

        // synchronous reset held 2 cycles mid-playback
        pb = 1'b0;
        rst = 1'b1;
        bus.en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_valid", 32'(bus.valid), 0);
        chk("mid_rst_play", 32'(bus.playback_signal), 0);
        chk("sb_drain_rst", 32'(exp_q.size()), 0);

        // full depth capture, length 0 -> 512 samples
        length = 9'd0;
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 512; k++) win[k] = 8'((k * 37 + 128) & 255);
        for (int k = 0; k < 512; k++) begin
            cyc(1'b1, win[k], 1'b0, 1'b0);
            if (k == 0) chk("full_cap", 32'(state), 2);
            if (k == 510) chk("full_notyet", 32'(state), 2);
        end
        chk("full_pb", 32'(state), 3);
        chk("full_done", 32'(done), 1);
        start_pb(512);
        for (int i = 0; i < 520; i++) begin
            cyc(1'b1, 8'h00, 1'b0, 1'b0);
            if (i == 0) chk("full_done_pulse", 32'(done), 0);
        end

        // length 1: trigger write is the last write
        length = 9'd1;
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        chk("len1_armed", 32'(state), 1);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("len1_novalid", 32'(bus.valid), 0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("len1_state", 32'(state), 3);
        chk("len1_done", 32'(done), 1);
        chk("len1_busy", 32'(busy), 0);
        win[0] = 8'hEE;
        start_pb(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        chk("stop_state", 32'(state), 0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("stop_valid", 32'(bus.valid), 0);
        chk("sb_drain_end", 32'(exp_q.size()), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sigcapture.md
# sigcapture

Triggered record-and-playback buffer for the signal-generator/microphone path. It reads the write side's sample stream: it waits for a rising level crossing on the incoming microphone samples and records a fixed-length window into an internal dual-port RAM. It then replays that window continuously as a looping output stream. It sits alongside the delay path and feeds the same DAC/VBuddy display output.

## Interface
- ADDRESS_WIDTH, 9, RAM address width; capture depth up to 2^ADDRESS_WIDTH samples
- DATA_WIDTH, 8, sample width (unsigned)
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  sample strobe; one sample consumed/produced per cycle with en=1
- arm  input  1  pulse; start waiting for trigger (latches length)
- stop  input  1  pulse; abort to IDLE from any state
- trigger_level  input  DATA_WIDTH  unsigned trigger threshold
- length  input  ADDRESS_WIDTH  capture length in samples; 0 means 2^ADDRESS_WIDTH
- mic_signal  input  DATA_WIDTH  incoming sample
- playback_signal  output  DATA_WIDTH  replayed sample
- valid  output  1  playback_signal holds a new sample this cycle
- busy  output  1  high in ARMED or CAPTURE
- done  output  1  one-cycle pulse when the last capture sample is written
- state  output  2  IDLE=0, ARMED=1, CAPTURE=2, PLAYBACK=3

## Operation
- Internal 2-port RAM: 2^ADDRESS_WIDTH x DATA_WIDTH, synchronous write, synchronous read (1-cycle latency). Contents are not cleared by reset.
- prev_sample register: loads mic_signal on every en cycle in every state. Reset value 0.
- IDLE: no writes, no reads. arm -> ARMED; len_q <= length.
- ARMED:
  - Trigger = en && mic_signal >= trigger_level && prev_sample < trigger_level (unsigned compare).
  - On trigger: write mic_signal to addr 0, wr_addr <= 1, -> CAPTURE.
  - If len_q == 1, the trigger write is the last one: -> PLAYBACK directly and pulse done.
- CAPTURE: each en cycle writes mic_signal at wr_addr and increments wr_addr. When the write at addr len_q-1 is performed (addr 2^AW-1 if len_q==0): pulse done, rd_addr <= 0, -> PLAYBACK.
- PLAYBACK:
  - Each en cycle issues a read at rd_addr.
  - rd_addr wraps from len_q-1 to 0 (natural ADDRESS_WIDTH wrap when len_q==0).
  - Loops indefinitely.
- arm in PLAYBACK -> ARMED: relatches length and stops reads; a read already in flight still completes with valid=1 the next cycle.
- arm in ARMED or CAPTURE is ignored.
- stop from any state -> IDLE. stop wins over simultaneous arm or trigger. An in-flight read still completes.
- Address arithmetic is modulo 2^ADDRESS_WIDTH; no carry out.

## Timing
- Reset values: playback_signal=0, valid=0, busy=0, done=0, state=0 (IDLE), wr_addr=0, rd_addr=0, len_q=0, prev_sample=0.
- rst asserted mid-capture or mid-playback: next cycle everything is at reset values. The RAM keeps partial data, but nothing is replayed until a new capture completes.
- arm pulse at edge N: state=ARMED at N+1. The first trigger evaluation uses mic_signal at N+1 or later.
- done is asserted in the cycle after the edge performing the final write, coincident with state=PLAYBACK.
- Playback latency: read issued at edge N (en=1) -> playback_signal updated and valid=1 at N+1 for exactly one cycle.
- playback_signal holds its last value when valid=0.
- en=0 stalls all activity (no write, no read, no prev_sample update); the state is held.
- A write and a read never target the same cycle; no read-during-write hazard exists.

## Test plan
- Reset: assert rst 2 cycles mid-PLAYBACK -> all outputs 0, state=0. Re-arming and capturing then works normally.
- Basic capture/replay: length=4, trigger_level=0x80, en=1 constant, samples 0x10,0x20,0x90,0xA0,0xB0,0xC0 -> trigger on 0x90; done pulses after 0xC0 is written. Output then loops 0x90,0xA0,0xB0,0xC0,0x90… with valid=1 each cycle.
- No false trigger: prev=0x90 and mic_signal=0x95 at arm time -> no trigger. A later sequence 0x40,0x81 -> triggers on 0x81.
- en gating: en toggling 1,0,1,0 during CAPTURE with length=3 -> only en cycles are written. Playback output advances only on en cycles, valid=0 on en=0 cycles.
- Full depth: length=0, ADDRESS_WIDTH=9 -> 512 samples captured. rd_addr wraps 511->0, and sample 0 reappears 512 en-cycles after the first playback sample.
- Control precedence: arm+stop in the same cycle during PLAYBACK -> IDLE. arm during CAPTURE -> ignored and capture completes. arm during PLAYBACK -> ARMED, valid drops after the in-flight read.
